// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, funct
// codes, ALU operation selects, state encoding and mux encodings.
package multicycle_control_pkg;

    // Opcodes of the supported MIPS subset
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation selects
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU operand B mux
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control FSM state encoding; codes 12-15 are unused
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_EXEC_I  = 4'd10,
        S_IWB     = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// Maps an R-type funct field to an ALU operation select and flags any
// funct outside the supported set. Purely combinational.
module alu_op_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] sel_op,
    output logic       illegal_funct
);

    // Unsupported funct codes select AND and raise the illegal flag
    always_comb begin
        sel_op        = ALU_AND;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  sel_op = ALU_ADD;
            FN_SUB:  sel_op = ALU_SUB;
            FN_AND:  sel_op = ALU_AND;
            FN_OR:   sel_op = ALU_OR;
            FN_NOR:  sel_op = ALU_NOR;
            FN_SLT:  sel_op = ALU_SLT;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM. The state register is the only storage;
// every datapath control is decoded from the current state plus the
// memReady / zeroFlag / opcode / funct inputs.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zeroFlag,
    input  logic       memReady,
    output logic [3:0] selOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] funct_op;
    logic       funct_illegal;

    alu_op_decode u_alu_op_decode (
        .funct         (funct),
        .sel_op        (funct_op),
        .illegal_funct (funct_illegal)
    );

    assign state = state_q;

    // State register, forced back to FETCH asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; strobes are suppressed while reset is held
    always_comb begin
        state_d  = state_q;
        selOp    = ALU_AND;
        aluSrcA  = 1'b0;
        aluSrcB  = SRCB_REGB;
        pcSource = PCSRC_ALU;
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        iorD     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                selOp   = ALU_ADD;
                irWrite = memReady;
                pcWrite = memReady;
                if (memReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrcB = SRCB_IMM_SH;
                selOp   = ALU_ADD;
                case (opcode)
                    OP_RTYPE:    state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:      state_d = S_BRANCH;
                    OP_ADDI:     state_d = S_EXEC_I;
                    OP_J:        state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                selOp   = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (memReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_REGB;
                selOp   = funct_op;
                if (funct_illegal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_RWB;
                end
            end
            S_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                selOp   = ALU_ADD;
                state_d = S_IWB;
            end
            S_IWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA  = 1'b1;
                aluSrcB  = SRCB_REGB;
                selOp    = ALU_SUB;
                pcSource = PCSRC_ALUOUT;
                pcWrite  = zeroFlag;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcSource = PCSRC_JUMP;
                pcWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            memWrite = 1'b0;
            regWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: steps instructions through the
// FSM and compares every control output against hand-written per-cycle values.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zeroFlag;
    logic       memReady;
    logic [3:0] selOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic       pcWrite;
    logic       irWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       illegal;
    logic [3:0] state;

    int compared;
    int mismatched;

    // Strobe groups, bit order {pcWrite,irWrite,iorD,memRead,memWrite,regWrite,regDst,memToReg,illegal}
    localparam logic [8:0] F_NONE       = 9'b000000000;
    localparam logic [8:0] F_FETCH      = 9'b110100000;
    localparam logic [8:0] F_FETCH_WAIT = 9'b000100000;
    localparam logic [8:0] F_MEMRD      = 9'b001100000;
    localparam logic [8:0] F_MEMWB      = 9'b000001010;
    localparam logic [8:0] F_MEMWR      = 9'b001010000;
    localparam logic [8:0] F_RWB        = 9'b000001100;
    localparam logic [8:0] F_IWB        = 9'b000001000;
    localparam logic [8:0] F_PCW        = 9'b100000000;
    localparam logic [8:0] F_ILL        = 9'b000000001;

    multicycle_control dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .funct    (funct),
        .zeroFlag (zeroFlag),
        .memReady (memReady),
        .selOp    (selOp),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .pcSource (pcSource),
        .pcWrite  (pcWrite),
        .irWrite  (irWrite),
        .iorD     (iorD),
        .memRead  (memRead),
        .memWrite (memWrite),
        .regWrite (regWrite),
        .regDst   (regDst),
        .memToReg (memToReg),
        .illegal  (illegal),
        .state    (state)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against the bench ever stalling
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%06h, want 0x%06h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic ready, input logic zero);
        opcode   = op;
        funct    = fn;
        memReady = ready;
        zeroFlag = zero;
    endtask

    // Compare the whole output word {state,selOp,aluSrcA,aluSrcB,pcSource,strobes}
    task automatic checkCycle(input string tag, input logic [3:0] st, input logic [3:0] sel,
                              input logic srcA, input logic [1:0] srcB, input logic [1:0] pcs,
                              input logic [8:0] flags);
        logic [31:0] observed;
        logic [31:0] expected;
        #1;
        observed = {10'd0, state, selOp, aluSrcA, aluSrcB, pcSource,
                    pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg, illegal};
        expected = {10'd0, st, sel, srcA, srcB, pcs, flags};
        checkOutput(tag, observed, expected);
    endtask

    task automatic stepClock();
        @(posedge clk);
        #2;
    endtask

    // FETCH with memReady high, then the common DECODE cycle
    task automatic fetchDecode(input string tag);
        checkCycle({tag, "_fetch"}, 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH);
        stepClock();
        checkCycle({tag, "_decode"}, 4'd1, 4'b0010, 1'b0, 2'b11, 2'b00, F_NONE);
        stepClock();
    endtask

    logic [5:0] fnTable  [6];
    logic [3:0] selTable [6];

    initial begin
        compared   = 0;
        mismatched = 0;
        fnTable  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        selTable = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

        // Reset and idle values
        rst_n = 1'b0;
        applyStimulus(6'h00, 6'h22, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkCycle("reset_idle", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH_WAIT);
        memReady = 1'b1;
        checkCycle("reset_ready_no_strobe", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH_WAIT);
        rst_n = 1'b1;

        // R-type SUB: 0,1,6,7,0
        fetchDecode("rsub");
        checkCycle("rsub_exec", 4'd6, 4'b0110, 1'b1, 2'b00, 2'b00, F_NONE);
        stepClock();
        checkCycle("rsub_rwb", 4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, F_RWB);
        stepClock();

        // LW with three wait cycles in MEMRD, eight cycles in total
        applyStimulus(6'h23, 6'h00, 1'b1, 1'b0);
        fetchDecode("lw");
        checkCycle("lw_addr", 4'd2, 4'b0010, 1'b1, 2'b10, 2'b00, F_NONE);
        stepClock();
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkCycle("lw_memrd_wait", 4'd3, 4'b0000, 1'b0, 2'b00, 2'b00, F_MEMRD);
            stepClock();
        end
        memReady = 1'b1;
        checkCycle("lw_memrd_done", 4'd3, 4'b0000, 1'b0, 2'b00, 2'b00, F_MEMRD);
        stepClock();
        checkCycle("lw_memwb", 4'd4, 4'b0000, 1'b0, 2'b00, 2'b00, F_MEMWB);
        stepClock();

        // Asynchronous reset in the middle of MEMRD
        fetchDecode("lwrst");
        stepClock();
        memReady = 1'b0;
        checkCycle("lwrst_memrd", 4'd3, 4'b0000, 1'b0, 2'b00, 2'b00, F_MEMRD);
        #2;
        rst_n = 1'b0;
        checkCycle("lwrst_async", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH_WAIT);
        memReady = 1'b1;
        checkCycle("lwrst_held", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH_WAIT);
        stepClock();
        rst_n = 1'b1;
        checkCycle("lwrst_release", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH);
        stepClock();
        stepClock();
        stepClock();
        checkCycle("lwrst_resume_memrd", 4'd3, 4'b0000, 1'b0, 2'b00, 2'b00, F_MEMRD);
        stepClock();
        stepClock();

        // SW with one wait cycle in MEMWR
        applyStimulus(6'h2B, 6'h00, 1'b1, 1'b0);
        fetchDecode("sw");
        checkCycle("sw_addr", 4'd2, 4'b0010, 1'b1, 2'b10, 2'b00, F_NONE);
        stepClock();
        memReady = 1'b0;
        checkCycle("sw_memwr_wait", 4'd5, 4'b0000, 1'b0, 2'b00, 2'b00, F_MEMWR);
        stepClock();
        memReady = 1'b1;
        checkCycle("sw_memwr_done", 4'd5, 4'b0000, 1'b0, 2'b00, 2'b00, F_MEMWR);
        stepClock();

        // BEQ taken and not taken
        applyStimulus(6'h04, 6'h00, 1'b1, 1'b1);
        fetchDecode("beq_t");
        checkCycle("beq_taken", 4'd8, 4'b0110, 1'b1, 2'b00, 2'b01, F_PCW);
        stepClock();
        applyStimulus(6'h04, 6'h00, 1'b1, 1'b0);
        fetchDecode("beq_n");
        checkCycle("beq_not_taken", 4'd8, 4'b0110, 1'b1, 2'b00, 2'b01, F_NONE);
        stepClock();

        // Jump
        applyStimulus(6'h02, 6'h00, 1'b1, 1'b0);
        fetchDecode("j");
        checkCycle("j_jump", 4'd9, 4'b0000, 1'b0, 2'b00, 2'b10, F_PCW);
        stepClock();

        // ADDI after one FETCH wait cycle
        applyStimulus(6'h08, 6'h00, 1'b0, 1'b0);
        checkCycle("addi_fetch_wait", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH_WAIT);
        stepClock();
        memReady = 1'b1;
        fetchDecode("addi");
        checkCycle("addi_exec", 4'd10, 4'b0010, 1'b1, 2'b10, 2'b00, F_NONE);
        stepClock();
        checkCycle("addi_iwb", 4'd11, 4'b0000, 1'b0, 2'b00, 2'b00, F_IWB);
        stepClock();

        // Unsupported opcode
        applyStimulus(6'h3F, 6'h00, 1'b1, 1'b0);
        checkCycle("illop_fetch", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH);
        stepClock();
        checkCycle("illop_decode", 4'd1, 4'b0010, 1'b0, 2'b11, 2'b00, F_ILL);
        stepClock();

        // Unsupported funct
        applyStimulus(6'h00, 6'h00, 1'b1, 1'b0);
        fetchDecode("illfn");
        checkCycle("illfn_exec", 4'd6, 4'b0000, 1'b1, 2'b00, 2'b00, F_ILL);
        stepClock();
        checkCycle("illfn_back", 4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, F_FETCH);

        // Every supported funct through EXEC_R and RWB
        for (int i = 0; i < 6; i++) begin
            applyStimulus(6'h00, fnTable[i], 1'b1, 1'b0);
            fetchDecode("rtab");
            checkCycle("rtab_exec", 4'd6, selTable[i], 1'b1, 2'b00, 2'b00, F_NONE);
            stepClock();
            checkCycle("rtab_rwb", 4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, F_RWB);
            stepClock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM. It is the producer side of the datapath ALU interface: it drives the 4-bit ALU operation select and the operand-mux selects, and it consumes the ALU zero flag.
- It sequences fetch, decode, execute, memory and writeback for a MIPS subset.
- It handshakes with a variable-latency memory through memReady.
- It sits beside the register file, IR, PC and ALU in the CPU top level.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load-word opcode
- OP_SW, 6'h2B, store-word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_ADDI, 6'h08, add-immediate opcode
- OP_J, 6'h02, jump opcode

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zeroFlag  in  1  ALU result==0
- memReady  in  1  memory completes the current read/write this cycle
- selOp  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
- aluSrcA  out  1  0=PC, 1=regA
- aluSrcB  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
- pcSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pcWrite  out  1  PC load strobe
- irWrite  out  1  IR load strobe
- iorD  out  1  memory address: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- regWrite  out  1  register file write strobe
- regDst  out  1  0=rt, 1=rd
- memToReg  out  1  0=ALUOut, 1=MDR
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- state  out  4  current state code, for debug

Behaviour:
- State register is the only sequential element.
  - rst_n low: asynchronously set state to FETCH and clear illegal.
  - Otherwise update on rising clk.
- Outputs are decoded combinationally from state, plus the listed gating. Any output not listed for a state is 0.
- Reset/idle output values (state FETCH): memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, selOp=0010, pcSource=00, irWrite=memReady, pcWrite=memReady, all other outputs 0.
- State codes:
  - FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, BRANCH=8, JUMP=9, EXEC_I=10, IWB=11.
  - Codes 12-15 go to FETCH.
- FETCH:
  - Hold in FETCH while memReady=0.
  - When memReady=1, pulse irWrite and pcWrite (PC+4) and go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, selOp=ADD (branch target into ALUOut). Next state by opcode:
  - R → EXEC_R
  - LW/SW → MEMADDR
  - BEQ → BRANCH
  - ADDI → EXEC_I
  - J → JUMP
  - other → FETCH with illegal=1 for one cycle
- MEMADDR: aluSrcA=1, aluSrcB=10, selOp=ADD. Next: LW → MEMRD, SW → MEMWR.
- MEMRD:
  - memRead=1, iorD=1.
  - Hold until memReady=1, then go to MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1, then go to FETCH.
- MEMWR:
  - memWrite=1, iorD=1.
  - Hold until memReady=1, then go to FETCH.
- EXEC_R: aluSrcA=1, aluSrcB=00. selOp from funct:
  - 20 → ADD
  - 22 → SUB
  - 24 → AND
  - 25 → OR
  - 27 → NOR
  - 2A → SLT
  - Any other funct: selOp=0000, illegal=1 for one cycle, next state FETCH with no writeback.
  - Legal funct: next state RWB.
- RWB: regWrite=1, regDst=1, memToReg=0, then go to FETCH.
- EXEC_I: aluSrcA=1, aluSrcB=10, selOp=ADD, then go to IWB.
- IWB: regWrite=1, regDst=0, memToReg=0, then go to FETCH.
- BRANCH:
  - aluSrcA=1, aluSrcB=00, selOp=SUB, pcSource=01.
  - pcWrite=zeroFlag in the same cycle, combinationally.
  - Next state FETCH.
- JUMP: pcSource=10, pcWrite=1, then go to FETCH.
- Cycle counts with memReady tied high:
  - R/ADDI/LW: 4/4/5.
  - SW/BEQ/J: 4/3/3.
- Each cycle memReady is low in FETCH, MEMRD or MEMWR adds one cycle.
- memRead and memWrite are never asserted in the same cycle.
- memRead and memWrite stay asserted and stable while waiting on memReady.
- Reset mid-operation: state returns to FETCH immediately and asynchronously. No write strobe fires in the reset cycle.

Decomposition:
- Shared package, used by the ALU and the ALU testbench:
  - Opcode and funct constants.
  - ALU op codes.
  - State encoding localparams.
  - aluSrcB and pcSource encodings.
- One sub-module, alu_op_decode: combinational function from funct to {selOp, illegal_funct}. It is reusable by the single-cycle variant.

Test Plan:
- Reset: rst_n=0 mid-MEMRD → state=0 asynchronously, memWrite=0, regWrite=0. Release with memReady=1 → irWrite=1, pcWrite=1 on the first cycle.
- R-type sub: opcode=00, funct=22, memReady=1 → states 0,1,6,7,0. selOp=0110 in EXEC_R; regWrite=1 and regDst=1 only in RWB.
- LW with wait: opcode=23, memReady low for 3 cycles in MEMRD → memRead=1 and iorD=1 held for 4 cycles; then MEMWB with memToReg=1. Total 8 cycles.
- BEQ, two cases: zeroFlag=1 in BRANCH → pcWrite=1 and pcSource=01. zeroFlag=0 → pcWrite=0. Both return to FETCH after 3 cycles.
- Illegal inputs, two cases: opcode=3F → illegal pulse in DECODE and no write strobes. funct=00 with opcode=00 → illegal in EXEC_R and no regWrite. Both return to FETCH.
- J and ADDI: opcode=02 → pcSource=10 and pcWrite=1 in JUMP. opcode=08 → selOp=0010 and aluSrcB=10 in EXEC_I, regWrite with regDst=0 in IWB.
